// File: rtl/apm_meas_seq_ctrl.sv
// APM measurement sequencer: power-up, settle and windowed edge count of the APM oscillator.
// Optional calibration phase is built in when APM_CAL_PHASE_EN is defined.
module apm_meas_seq_ctrl #(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 64,
    parameter int CAL_CYC    = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_osc_sel,
    input  logic             cfg_step,
    input  logic [1:0]       cfg_xtor_sel,
    input  logic [3:0]       cfg_mux_sel,
    input  logic [3:0]       cfg_vdac_sel,
    input  logic [WIN_W-1:0] cfg_win_len,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             overflow,
    output logic             apm_en_cal,
    output logic             apm_en_osc,
    output logic             apm_en_sensor,
    output logic             apm_en_step,
    output logic             apm_osc_sel,
    output logic [1:0]       apm_xtor_sel,
    output logic [3:0]       apm_mux_sel,
    output logic [3:0]       apm_vdac_sel,
    input  logic             apm_osc_out,
    output logic [2:0]       dbg_state
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int CAL_W = $clog2(CAL_CYC + 1);
    localparam int PH_W  = (SET_W > CAL_W) ? SET_W : CAL_W;
    localparam int TMR_W = (WIN_W > PH_W) ? WIN_W : PH_W;
    localparam logic [TMR_W-1:0] SET_LOAD = TMR_W'(SETTLE_CYC - 1);
`ifdef APM_CAL_PHASE_EN
    localparam logic [TMR_W-1:0] CAL_LOAD = TMR_W'(CAL_CYC - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CAL    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_MEAS   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               accept;

    logic               osc_sel_q, step_q;
    logic [1:0]         xtor_q;
    logic [3:0]         mux_q, vdac_q;
    logic [WIN_W-1:0]   win_q;

    logic               sync1_q, sync2_q, prev_q, edge_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   result_q, result_d;

    assign accept = (state_q == ST_IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Phase timer counts down from length-1; a phase ends when it reads zero.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        if (state_q != ST_IDLE && abort) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
`ifdef APM_CAL_PHASE_EN
                        state_d = ST_CAL;
                        tmr_d   = CAL_LOAD;
`else
                        state_d = ST_SETTLE;
                        tmr_d   = SET_LOAD;
`endif
                    end
                end
                ST_CAL: begin
                    if (tmr_q == '0) begin
                        state_d = ST_SETTLE;
                        tmr_d   = SET_LOAD;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_q == '0) begin
                        if (win_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_MEAS;
                            tmr_d   = TMR_W'(win_q) - 1'b1;
                        end
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (tmr_q == '0) state_d = ST_DONE;
                    else             tmr_d   = tmr_q - 1'b1;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        apm_en_cal    = 1'b0;
        apm_en_sensor = 1'b0;
        apm_en_osc    = 1'b0;
        apm_osc_sel   = 1'b0;
        apm_en_step   = 1'b0;
        apm_xtor_sel  = '0;
        apm_mux_sel   = '0;
        apm_vdac_sel  = '0;
        case (state_q)
            ST_CAL: begin
                busy          = 1'b1;
                apm_en_sensor = 1'b1;
`ifdef APM_CAL_PHASE_EN
                apm_en_cal    = 1'b1;
`endif
            end
            ST_SETTLE: begin
                busy          = 1'b1;
                apm_en_sensor = 1'b1;
            end
            ST_MEAS: begin
                busy          = 1'b1;
                apm_en_sensor = 1'b1;
                apm_en_osc    = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
        // Select pins hold the latched configuration for the whole run, DONE included.
        if (state_q != ST_IDLE) begin
            apm_osc_sel  = osc_sel_q;
            apm_en_step  = step_q;
            apm_xtor_sel = xtor_q;
            apm_mux_sel  = mux_q;
            apm_vdac_sel = vdac_q;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            osc_sel_q <= 1'b0;
            step_q    <= 1'b0;
            xtor_q    <= '0;
            mux_q     <= '0;
            vdac_q    <= '0;
            win_q     <= '0;
        end else if (accept) begin
            osc_sel_q <= cfg_osc_sel;
            step_q    <= cfg_step;
            xtor_q    <= cfg_xtor_sel;
            mux_q     <= cfg_mux_sel;
            vdac_q    <= cfg_vdac_sel;
            win_q     <= cfg_win_len;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (state_q == ST_MEAS && !abort && edge_q) begin
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + 1'b1;
        end
        // Capture includes an edge counted on the final MEAS cycle.
        result_d = (state_d == ST_DONE) ? cnt_d : result_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            edge_q   <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            sync1_q  <= apm_osc_out;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            edge_q   <= sync2_q & ~prev_q;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    assign result    = result_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_apm_meas_seq_ctrl.sv
// Bench for apm_meas_seq_ctrl: directed scenarios with literal expectations plus randomized
// runs checked every cycle against a phase-arithmetic model of the sequence.
module tb_apm_meas_seq_ctrl;

    localparam int CNT_W = 5;
    localparam int WIN_W = 8;
    localparam int S     = 64;
    localparam int CALC  = 32;
`ifdef APM_CAL_PHASE_EN
    localparam int P = CALC;
`else
    localparam int P = 0;
`endif
    localparam int CMAX = (1 << CNT_W) - 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    logic             start, abort, cfg_osc_sel, cfg_step;
    logic [1:0]       cfg_xtor_sel;
    logic [3:0]       cfg_mux_sel, cfg_vdac_sel;
    logic [WIN_W-1:0] cfg_win_len;
    logic             busy, done, overflow;
    logic [CNT_W-1:0] result;
    logic             apm_en_cal, apm_en_osc, apm_en_sensor, apm_en_step, apm_osc_sel;
    logic [1:0]       apm_xtor_sel;
    logic [3:0]       apm_mux_sel, apm_vdac_sel;
    logic             apm_osc_out;
    logic [2:0]       dbg_state;

    apm_meas_seq_ctrl #(
        .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(S), .CAL_CYC(CALC)
    ) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
        .cfg_osc_sel(cfg_osc_sel), .cfg_step(cfg_step), .cfg_xtor_sel(cfg_xtor_sel),
        .cfg_mux_sel(cfg_mux_sel), .cfg_vdac_sel(cfg_vdac_sel), .cfg_win_len(cfg_win_len),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .apm_en_cal(apm_en_cal), .apm_en_osc(apm_en_osc), .apm_en_sensor(apm_en_sensor),
        .apm_en_step(apm_en_step), .apm_osc_sel(apm_osc_sel), .apm_xtor_sel(apm_xtor_sel),
        .apm_mux_sel(apm_mux_sel), .apm_vdac_sel(apm_vdac_sel),
        .apm_osc_out(apm_osc_out), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 8;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a run is a start cycle c0 plus a window; phase = cycle - c0.
    bit         m_act;
    int         m_c0, m_w, m_cnt, m_res;
    bit         m_ovf;
    logic       m_osc_sel, m_step;
    logic [1:0] m_xtor;
    logic [3:0] m_mux, m_vdac;
    bit         hist[8];

    always @(posedge clk or negedge rst_b) begin
        int  k;
        bit  det;
        if (!rst_b) begin
            m_act <= 1'b0;
            m_cnt <= 0;
            m_res <= 0;
            m_ovf <= 1'b0;
            for (int i = 0; i < 8; i++) hist[i] <= 1'b0;
        end else begin
            hist[cyc % 8] <= apm_osc_out;
            // an oscillator rising edge is counted three cycles after it arrives
            det = hist[(cyc - 3) % 8] && !hist[(cyc - 4) % 8];
            k   = cyc - m_c0;
            if (m_act) begin
                if (k == P + S + m_w + 1) begin
                    m_res <= m_cnt;
                    m_act <= 1'b0;
                end else if (abort) begin
                    m_act <= 1'b0;
                end else if (k > P + S && det) begin
                    if (m_cnt == CMAX) m_ovf <= 1'b1;
                    else               m_cnt <= m_cnt + 1;
                end
            end else if (start && !abort) begin
                m_act     <= 1'b1;
                m_c0      <= cyc;
                m_w       <= int'(cfg_win_len);
                m_osc_sel <= cfg_osc_sel;
                m_step    <= cfg_step;
                m_xtor    <= cfg_xtor_sel;
                m_mux     <= cfg_mux_sel;
                m_vdac    <= cfg_vdac_sel;
                m_cnt     <= 0;
                m_ovf     <= 1'b0;
            end
            cyc <= cyc + 1;
        end
    end

    // scoreboard compare on every falling edge
    always @(negedge clk) begin
        int k;
        bit in_cal, in_set, in_meas, in_done, run;
        if (rst_b && mon_en) begin
            k       = cyc - m_c0;
            in_cal  = m_act && k >= 1 && k <= P;
            in_set  = m_act && k > P && k <= P + S;
            in_meas = m_act && k > P + S && k <= P + S + m_w;
            in_done = m_act && k == P + S + m_w + 1;
            run     = in_cal || in_set || in_meas;
            chk("busy", int'(busy), int'(run));
            chk("done", int'(done), int'(in_done));
            chk("en_cal", int'(apm_en_cal), int'(in_cal));
            chk("en_sensor", int'(apm_en_sensor), int'(run));
            chk("en_osc", int'(apm_en_osc), int'(in_meas));
            chk("osc_sel", int'(apm_osc_sel), m_act ? int'(m_osc_sel) : 0);
            chk("en_step", int'(apm_en_step), m_act ? int'(m_step) : 0);
            chk("xtor_sel", int'(apm_xtor_sel), m_act ? int'(m_xtor) : 0);
            chk("mux_sel", int'(apm_mux_sel), m_act ? int'(m_mux) : 0);
            chk("vdac_sel", int'(apm_vdac_sel), m_act ? int'(m_vdac) : 0);
            chk("result", int'(result), in_done ? m_cnt : m_res);
            chk("overflow", int'(overflow), int'(m_ovf));
        end
    end

    // oscillator: 0 = off, 1 = period 4, 2 = random half-periods of 2..5 cycles
    int osc_mode = 0;
    int osc_run  = 0;
    initial begin
        apm_osc_out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (osc_mode == 0) begin
                apm_osc_out = 1'b0;
            end else if (osc_run <= 0) begin
                apm_osc_out = ~apm_osc_out;
                osc_run = (osc_mode == 1) ? 1 : int'($urandom_range(1, 4));
            end else begin
                osc_run--;
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        cfg_osc_sel  = 1'($urandom_range(0, 1));
        cfg_step     = 1'($urandom_range(0, 1));
        cfg_xtor_sel = 2'($urandom_range(0, 3));
        cfg_mux_sel  = 4'($urandom_range(0, 15));
        cfg_vdac_sel = 4'($urandom_range(0, 15));
        cfg_win_len  = WIN_W'($urandom_range(0, 255));
    endtask

    task automatic start_run(input int w, input logic [3:0] mux, output int c0);
        tick();
        scramble();
        cfg_mux_sel = mux;
        cfg_win_len = WIN_W'(w);
        start = 1'b1;
        abort = 1'b0;
        c0 = cyc;
        tick();
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input int budget, input bit chk_mux, input logic [3:0] mux_exp,
                             output int done_cyc, output int osc_n, output int cal_n);
        done_cyc = -1;
        osc_n    = 0;
        cal_n    = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (apm_en_osc) osc_n++;
            if (apm_en_cal) cal_n++;
            if (chk_mux) chk("mux_hold", int'(apm_mux_sel), int'(mux_exp));
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        tick();
    endtask

    initial begin
        int c0, c1, n, d, osc_n, cal_n, w, ab;
        rst_b = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_apm_pins", int'({apm_en_cal, apm_en_osc, apm_en_sensor, apm_en_step,
                                    apm_osc_sel, apm_xtor_sel, apm_mux_sel, apm_vdac_sel}), 0);
        rst_b  = 1'b1;
        mon_en = 1'b1;

        // basic count, period-4 oscillator, W=100
        osc_mode = 1;
        start_run(100, 4'h3, c0);
        wait_done(400, 1'b1, 4'h3, d, osc_n, cal_n);
        chk("basic_done_cycle", d - c0, P + 165);
        chk("basic_osc_cycles", osc_n, 100);
        chk("basic_result_24_25", int'(result == 5'd24 || result == 5'd25), 1);
        chk("basic_overflow", int'(overflow), 0);
        chk("cal_cycles", cal_n, P);

        // saturation
        start_run(200, 4'h6, c0);
        wait_done(500, 1'b1, 4'h6, d, osc_n, cal_n);
        chk("sat_result", int'(result), 31);
        chk("sat_overflow", int'(overflow), 1);

        // zero window, config churn and a start during SETTLE
        start_run(0, 4'hA, c0);
        chk("ovf_cleared_by_start", int'(overflow), 0);
        tick();
        start = 1'b1;
        cfg_mux_sel = 4'h5;
        cfg_win_len = 8'd9;
        tick();
        start = 1'b0;
        scramble();
        wait_done(200, 1'b1, 4'hA, d, osc_n, cal_n);
        chk("zero_done_cycle", d - c0, P + 65);
        chk("zero_osc_cycles", osc_n, 0);
        chk("zero_result", int'(result), 0);

        // abort 10 cycles into MEAS, then an immediate restart
        start_run(100, 4'h5, c0);
        repeat (P + S + 10) tick();
        abort = 1'b1;
        n = cyc;
        tick();
        abort = 1'b0;
        chk("abort_next_cycle", cyc - n, 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_apm_pins", int'({apm_en_cal, apm_en_osc, apm_en_sensor, apm_en_step,
                                    apm_osc_sel, apm_xtor_sel, apm_mux_sel, apm_vdac_sel}), 0);
        chk("abort_result_kept", int'(result), 0);
        cfg_win_len = 8'd20;
        start = 1'b1;
        c1 = cyc;
        tick();
        start = 1'b0;
        chk("abort_restart_busy", int'(busy), 1);
        wait_done(300, 1'b0, 4'h0, d, osc_n, cal_n);
        chk("abort_restart_done_cycle", d - c1, P + 85);
        chk("abort_restart_result", int'(result), 5);

        // start with abort in IDLE is ignored
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_sensor", int'(apm_en_sensor), 0);

        // asynchronous reset mid-MEAS
        start_run(100, 4'h7, c0);
        repeat (P + S + 20) tick();
        #3;
        rst_b = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_apm_pins", int'({apm_en_cal, apm_en_osc, apm_en_sensor, apm_en_step,
                                  apm_osc_sel, apm_xtor_sel, apm_mux_sel, apm_vdac_sel}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        start_run(20, 4'h1, c0);
        wait_done(300, 1'b1, 4'h1, d, osc_n, cal_n);
        chk("post_rst_done_cycle", d - c0, P + 85);
        chk("post_rst_result", int'(result), 5);

        // randomized runs with start noise and occasional aborts
        osc_mode = 2;
        for (int r = 0; r < 30; r++) begin
            repeat ($urandom_range(0, 4)) tick();
            w  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, P + S + w + 1)) : -1;
            start_run(w, 4'($urandom_range(0, 15)), c0);
            for (int k = 1; k <= P + S + w + 1; k++) begin
                start = ($urandom_range(0, 9) == 0);
                abort = (k == ab);
                scramble();
                tick();
                if (k == ab) break;
            end
            start = 1'b0;
            abort = 1'b0;
        end

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errs++;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apm_meas_seq_ctrl.md
# apm_meas_seq_ctrl

Measurement sequencer for the APM (analog process monitor) hard IP. It takes a single start request with a configuration word and drives the APM enable and select pins through a fixed power-up, settle and measure sequence. During a programmed clock window it counts rising edges of the APM oscillator output and returns the count with a done pulse. It sits between the UPM register/test-access logic and the APM HIP instance, and is the only driver of the HIP's control pins.

## Interface
- `CNT_W`, default 16: width of the edge-count result.
- `WIN_W`, default 16: width of the measurement-window length.
- `SETTLE_CYC`, default 64: number of clk cycles `apm_en_sensor` is held before the oscillator is enabled (minimum 1).
- `CAL_CYC`, default 32: length of the calibration phase, used only when `APM_CAL_PHASE_EN` is defined (minimum 1).

Ports:
- `clk` in 1: single clock.
- `rst_b` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `abort` in 1: cancels any operation in progress.
- `cfg_osc_sel` in 1: oscillator select, latched at start.
- `cfg_step` in 1: step-mode enable, latched at start.
- `cfg_xtor_sel` in 2: transistor select, latched at start.
- `cfg_mux_sel` in 4: mux select, latched at start.
- `cfg_vdac_sel` in 4: VDAC code, latched at start.
- `cfg_win_len` in WIN_W: window length in clk cycles, latched at start.
- `busy` out 1: high from the cycle after an accepted start until the return to IDLE.
- `done` out 1: one-cycle pulse when the result is valid.
- `result` out CNT_W: edge count; holds its value until the next done.
- `overflow` out 1: sticky saturation flag; cleared by the next accepted start.
- `apm_en_cal`, `apm_en_osc`, `apm_en_sensor`, `apm_en_step`, `apm_osc_sel` out 1: HIP controls.
- `apm_xtor_sel` out 2, `apm_mux_sel` out 4, `apm_vdac_sel` out 4: HIP controls.
- `apm_osc_out` in 1: HIP oscillator output; asynchronous to clk.

## Operation
State machine: IDLE → [CAL] → SETTLE → MEAS → DONE → IDLE.

- **Reset:** the state is IDLE and every output is 0, including `result` and `overflow`.
- **IDLE:** `start`=1 with `abort`=0 latches all `cfg_*` inputs, clears the counter and `overflow`, and moves to the next state. If `start` and `abort` are both 1, the start is ignored.
- **Select pins:** `apm_osc_sel`, `apm_xtor_sel`, `apm_mux_sel`, `apm_vdac_sel` and `apm_en_step` follow the latched values from the cycle after start. They stay stable through DONE and return to 0 in IDLE.
- **CAL** (macro only): `apm_en_cal`=1 and `apm_en_sensor`=1 for CAL_CYC cycles.
- **SETTLE:** `apm_en_sensor`=1 for SETTLE_CYC cycles.
- **MEAS:** `apm_en_sensor`=1 and `apm_en_osc`=1 for `cfg_win_len` cycles.
  - `apm_osc_out` passes through a 2-flop synchronizer followed by a rising-edge detect flop.
  - Each detected edge in MEAS increments the counter.
  - The counter saturates at all ones and sets `overflow`.
  - `cfg_win_len`=0: MEAS is skipped, `apm_en_osc` never asserts, and `result`=0.
- **DONE:** all enables are 0, `result` is loaded from the counter, `done`=1 for one cycle, then the state returns to IDLE.
- **Start outside IDLE:** a `start` in any other state is ignored and the latched configuration is unchanged.
- **Abort:** in any non-IDLE state, the next state is IDLE with all enables 0. No `done` is issued and `result` keeps its previous value.
- **Oscillator rate:** accurate counts require an `apm_osc_out` period greater than 2 clk cycles. Faster input undercounts; this is not flagged.

## Timing
- Start sampled at cycle 0. At cycle 1: `busy`=1, `apm_en_sensor`=1, select pins valid.
- `apm_en_osc` rises at cycle 1+SETTLE_CYC (+CAL_CYC when the macro is defined).
- `done` occurs at cycle 1+SETTLE_CYC+W (+CAL_CYC), where W = `cfg_win_len`. `busy` falls in the same cycle as `done`.
- Minimum spacing from one accepted start to the next is SETTLE_CYC+W+2 cycles.
- Counting latency: an `apm_osc_out` edge is counted 3 clk cycles after it arrives. Edges arriving during the last 3 cycles of MEAS are not counted.
- Abort at cycle N: outputs are 0 at cycle N+1, and a new start is accepted at cycle N+1.

## Configuration
- `APM_CAL_PHASE_EN` defined: the CAL state is present and `apm_en_cal` pulses for CAL_CYC cycles at the start of every measurement.
- Not defined: there is no CAL state, `apm_en_cal` is tied to 0, and the sequence goes directly IDLE → SETTLE.

## Test plan
- **Basic count:** SETTLE_CYC=64, W=100. `apm_osc_out` toggles every 2 clk cycles (period 4) → `apm_en_osc` high for exactly 100 cycles, `done` at cycle 165, `result`=24 or 25, `overflow`=0.
- **Saturation:** CNT_W=4, W=200, period-4 oscillator → `result`=15, `overflow`=1. The next start clears `overflow` to 0.
- **Abort mid-window:** abort 10 cycles into MEAS → all `apm_*` outputs 0 the next cycle, no `done`, `result` keeps its previous value, and an immediate new start is accepted.
- **Zero window and select stability:** `cfg_win_len`=0 → `apm_en_osc` never asserts, `done` at cycle 65, `result`=0. Separately, with `cfg_mux_sel`=4'hA, change the inputs during the run → `apm_mux_sel` stays 4'hA until DONE.
- **Start while busy / start with abort:** `start` during SETTLE is ignored with the configuration unchanged. `start`=1 with `abort`=1 in IDLE → `busy` stays 0.
- **Reset mid-MEAS:** assert `rst_b`=0 → all outputs 0 immediately (asynchronously). After release the block is in IDLE and a start runs normally. With `APM_CAL_PHASE_EN` defined, also check that `apm_en_cal` is high for exactly 32 cycles.
